// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default data width and the output-buffer occupancy encoding.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_ONE   = OCC_ONE,
        ST_TWO   = OCC_TWO
    } occ_e;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outgoing valid/ready stream; master = the reader engine.
interface fifo_stream_reader_if #(
    parameter int DATA_W = fifo_pkg::FIFO_DATA_W
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_en;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              m_last;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/stream_out_buf.sv
// Two-entry in-order output buffer: captures a word (plus last tag) and presents
// the head on a valid/ready port. Slot 0 is always the head.
module stream_out_buf
    import fifo_pkg::*;
#(
    parameter int W = FIFO_DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cap,
    input  logic [W-1:0] cap_data,
    input  logic         cap_last,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         last,
    output logic [1:0]   occ
);

    occ_e       occ_reg, occ_next;
    logic [W:0] slot_reg  [2];
    logic [W:0] slot_next [2];
    logic [W:0] cap_word;
    logic       consume;

    assign cap_word = {cap_last, cap_data};
    assign valid    = (occ_reg != ST_EMPTY);
    assign consume  = valid & ready;
    assign data     = slot_reg[0][W-1:0];
    assign last     = slot_reg[0][W];
    assign occ      = occ_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg     <= ST_EMPTY;
            slot_reg[0] <= '0;
            slot_reg[1] <= '0;
        end else begin
            occ_reg     <= occ_next;
            slot_reg[0] <= slot_next[0];
            slot_reg[1] <= slot_next[1];
        end
    end

    // Next occupancy is occ + capture - consume; simultaneous capture and
    // consume shifts the queue so the oldest word stays at the head.
    always_comb begin
        occ_next     = occ_reg;
        slot_next[0] = slot_reg[0];
        slot_next[1] = slot_reg[1];
        case (occ_reg)
            ST_EMPTY: begin
                if (cap) begin
                    slot_next[0] = cap_word;
                    occ_next     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (cap && consume) begin
                    slot_next[0] = cap_word;
                end else if (cap) begin
                    slot_next[1] = cap_word;
                    occ_next     = ST_TWO;
                end else if (consume) begin
                    occ_next     = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    slot_next[0] = slot_reg[1];
                    if (cap) begin
                        slot_next[1] = cap_word;
                    end else begin
                        occ_next = ST_ONE;
                    end
                end
            end
            default: occ_next = ST_EMPTY;
        endcase
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine: pops the FIFO under a 2-word credit and streams words out.
// Optional packet framing on m_last is enabled by defining STREAM_LAST_EN.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W  = FIFO_DATA_W,
    parameter int PKT_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    fifo_stream_reader_if.master bus
);

    logic       inflight_reg;
    logic       rd_en;
    logic       consume;
    logic       credit_ok;
    logic       cap_last;
    logic [1:0] occ;
    logic       buf_valid;

    assign consume = buf_valid & bus.m_ready;

    // occ + inflight - consume < 2, rearranged to avoid unsigned underflow.
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, consume});
    assign rd_en     = rst_n & en & ~bus.fifo_empty & credit_ok;
    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = buf_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= rd_en;
        end
    end

`ifdef STREAM_LAST_EN
    localparam int CNT_W = cnt_width(PKT_LEN);

    logic [CNT_W-1:0] beat_reg;

    // Beats are tagged as they enter the in-order buffer, so the tag travels
    // with its word and stays stable under backpressure.
    assign cap_last = (beat_reg == CNT_W'(PKT_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_reg <= '0;
        end else if (inflight_reg) begin
            beat_reg <= cap_last ? '0 : beat_reg + 1'b1;
        end
    end
`else
    assign cap_last = 1'b0;
`endif

    stream_out_buf #(
        .W (DATA_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap      (inflight_reg),
        .cap_data (bus.fifo_rd_data),
        .cap_last (cap_last),
        .ready    (bus.m_ready),
        .valid    (buf_valid),
        .data     (bus.m_data),
        .last     (bus.m_last),
        .occ      (occ)
    );

endmodule
